event_input_fifo: RTL and testbench
===================================

Name: event_input_fifo

Overview:
- Buffers incoming spike events from the input source and presents them one at a time to the Convolution2d stage.
- Input side uses a valid/ready handshake. Output side drives event_in / event_valid / event_ack exactly as Convolution2d consumes them.
- Absorbs bursts while the conv stage performs read-modify-write on the membrane BRAM through the arbiter.
- Reports fill level, overflow and dropped-event count to control.

Parameters:
- DEPTH, 16, storage entries in the FIFO array (power of two, ≥2).
- COORD_BITS, 8, width of the x and y coordinates.
- IN_CHANNELS, 2, width of the spike vector (one bit per input channel).
- TIMESTEP_BITS, 8, width of the timestep field of output_vector_t.
- IMG_WIDTH, 8, image width used by the optional bounds check.
- IMG_HEIGHT, 8, image height used by the optional bounds check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stored events.
- in_valid  in  1  input event present.
- in_ready  out  1  FIFO can accept an input event.
- in_timestep  in  TIMESTEP_BITS  event timestep.
- in_x  in  COORD_BITS  event x coordinate.
- in_y  in  COORD_BITS  event y coordinate.
- in_spikes  in  IN_CHANNELS  per-channel spike bits.
- event_out  out  output_vector_t  head event {timestep, x, y, spikes}; connects to conv event_in.
- event_valid  out  1  event_out holds a valid event.
- event_ack  in  1  consumer took event_out (one-cycle pulse).
- fill_level  out  $clog2(DEPTH)+1  events in the array, excluding the output register.
- overflow  out  1  sticky flag: an event was offered while full.
- drop_count  out  16  saturating count of dropped events.

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high; it takes priority over flush and all other inputs.
- Reset values: in_ready=0 during reset and 1 from the first cycle after; event_valid=0; event_out='0; fill_level=0; overflow=0; drop_count=0.
- Storage: a DEPTH-entry circular array with wr_ptr and rd_ptr ($clog2(DEPTH) bits, natural wrap) and count (0..DEPTH), plus one output register (OREG). Maximum occupancy is DEPTH+1.
- in_ready = (count < DEPTH) && !rst && !flush.
- Push: the event is accepted when in_valid && in_ready at a clk edge. A write on the same edge that the array is popped is always allowed.
- Drop: in_valid && !in_ready && !rst && !flush counts as a drop. The event is discarded, overflow is set (sticky until rst), and drop_count increments, saturating at 0xFFFF.
- OREG states:
  - EMPTY: event_valid=0.
  - HOLD: event_valid=1; event_out is stable until acked.
- EMPTY → HOLD:
  - Entered when count>0; loads the array head (pop) at the next edge.
  - An event pushed into an empty array is therefore visible on event_valid two edges after acceptance. The array is not bypassed.
- HOLD, event_ack=1:
  - If count>0, OREG reloads from the head at the same edge; event_valid stays 1 and event_out changes.
  - If count=0, OREG goes to EMPTY.
- HOLD, event_ack=0: hold. event_valid is never withdrawn without an ack.
- event_ack while EMPTY: ignored, no state change.
- Simultaneous push and pop: count is unchanged and the pointers both advance.
- Full plus pop on the same edge: in_ready was 0, so the input is dropped even though space frees at that edge. No look-ahead.
- flush=1: count, pointers and OREG are cleared, and event_valid=0 next cycle. Any input offered in the same cycle is dropped but not counted. overflow and drop_count are retained.
- Reset asserted mid-operation: all state is cleared at that edge; any event in HOLD is lost.
- Events leave in the order they were accepted; the timestep field passes through unchanged.

Optional Feature:
- Macro: EVENT_FIFO_BOUNDS_CHECK_EN.
- Defined: an accepted event with in_x ≥ IMG_WIDTH or in_y ≥ IMG_HEIGHT is consumed (in_ready behaves normally) but not written. It increments drop_count and does not set overflow.
- Undefined: all events are stored unchanged; no comparators are present.

Decomposition:
- snn_interfaces_pkg:
  - Reuse output_vector_t.
  - Add EVENT_FIFO_DEPTH_DEFAULT.
  - Add DROP_COUNT_BITS=16.
  - Add typedef oreg_state_t {OREG_EMPTY, OREG_HOLD}.
- Sub-module event_fifo_mem: a DEPTH×$bits(output_vector_t) array with a synchronous write port and a combinational read at rd_ptr. Pointer, count and OREG logic stay in event_input_fifo.

Test Plan:
- Single event: push {ts=0, x=5, y=3, spikes=2'b11} into an empty FIFO → event_valid rises 2 edges later with matching event_out. It holds until a 1-cycle event_ack; event_valid=0 on the following cycle.
- Burst: push 16 events (x=0..15) without acks → fill_level=15 with OREG holding x=0, in_ready stays 1. Push 17th event → fill_level=16, in_ready=0. The 18th offered event is dropped: overflow=1, drop_count=1.
- Drain: from full, pulse event_ack every cycle → event_out x sequence 0..16 is contiguous with no bubbles. event_valid falls after the 17th ack.
- Concurrent: push every cycle while acking every cycle at steady state → fill_level is constant, there are no drops, and order is preserved across pointer wrap (run 40 events).
- Flush and reset: with 5 events stored, assert flush for 1 cycle → event_valid=0, fill_level=0, overflow unchanged. Then assert rst mid-HOLD → all outputs return to reset values.
- With EVENT_FIFO_BOUNDS_CHECK_EN defined: push x=8,y=0 then x=7,y=7 (IMG 8×8) → only (7,7) reaches event_out; drop_count=1, overflow=0.

Source files
------------

// File: rtl/snn_interfaces_pkg.sv
// Shared SNN datapath types: the event vector passed between stages and
// the event FIFO's output-register state.
package snn_interfaces_pkg;

  localparam int SNN_TIMESTEP_BITS        = 8;
  localparam int SNN_COORD_BITS           = 8;
  localparam int SNN_IN_CHANNELS          = 2;
  localparam int EVENT_FIFO_DEPTH_DEFAULT = 16;
  localparam int DROP_COUNT_BITS          = 16;

  typedef struct packed {
    logic [SNN_TIMESTEP_BITS-1:0] timestep;
    logic [SNN_COORD_BITS-1:0]    x;
    logic [SNN_COORD_BITS-1:0]    y;
    logic [SNN_IN_CHANNELS-1:0]   spikes;
  } output_vector_t;

  typedef enum logic {
    OREG_EMPTY,
    OREG_HOLD
  } oreg_state_t;

endpackage

// File: rtl/event_fifo_mem.sv
// Event storage array for event_input_fifo: synchronous write port and a
// combinational read of the entry at the read pointer.
module event_fifo_mem
  import snn_interfaces_pkg::*;
#(
  parameter int DEPTH    = EVENT_FIFO_DEPTH_DEFAULT,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [PTR_BITS-1:0] wr_ptr_i,
  input  output_vector_t      wr_data_i,
  input  logic [PTR_BITS-1:0] rd_ptr_i,
  output output_vector_t      rd_data_o
);

  output_vector_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/event_input_fifo.sv
// Spike-event input FIFO feeding Convolution2d: circular array plus one output
// register. Define EVENT_FIFO_BOUNDS_CHECK_EN to discard off-image events.
module event_input_fifo
  import snn_interfaces_pkg::*;
#(
  parameter int DEPTH         = EVENT_FIFO_DEPTH_DEFAULT,
  parameter int COORD_BITS    = SNN_COORD_BITS,
  parameter int IN_CHANNELS   = SNN_IN_CHANNELS,
  parameter int TIMESTEP_BITS = SNN_TIMESTEP_BITS,
  parameter int IMG_WIDTH     = 8,
  parameter int IMG_HEIGHT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIMESTEP_BITS-1:0]   in_timestep,
  input  logic [COORD_BITS-1:0]      in_x,
  input  logic [COORD_BITS-1:0]      in_y,
  input  logic [IN_CHANNELS-1:0]     in_spikes,
  output output_vector_t             event_out,
  output logic                       event_valid,
  input  logic                       event_ack,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic [DROP_COUNT_BITS-1:0] drop_count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic [PTR_BITS:0] DEPTH_C = (PTR_BITS+1)'(DEPTH);

  logic [PTR_BITS-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]          count_q, count_d;
  oreg_state_t                state_q, state_d;
  output_vector_t             oreg_q, oreg_d;
  logic                       overflow_q, overflow_d;
  logic [DROP_COUNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  logic           ready_c;
  logic           accept_c;
  logic           in_bounds_c;
  logic           wr_en_c;
  logic           pop_c;
  logic           drop_inc_c;
  output_vector_t wr_data_c;
  output_vector_t head_c;

  assign ready_c   = (count_q < DEPTH_C) && !rst && !flush;
  assign accept_c  = in_valid && ready_c;
  assign wr_data_c = {in_timestep, in_x, in_y, in_spikes};

`ifdef EVENT_FIFO_BOUNDS_CHECK_EN
  assign in_bounds_c = (32'(in_x) < IMG_WIDTH) && (32'(in_y) < IMG_HEIGHT);
`else
  assign in_bounds_c = 1'b1;
`endif

  assign wr_en_c = accept_c && in_bounds_c;

  event_fifo_mem #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en_c),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (wr_data_c),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (head_c)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    oreg_d     = oreg_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    pop_c      = 1'b0;
    drop_inc_c = 1'b0;

    // The output register pulls from the array head whenever it is free or being acked.
    unique case (state_q)
      OREG_EMPTY: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_d = OREG_HOLD;
        end
      end
      OREG_HOLD: begin
        if (event_ack) begin
          if (count_q != '0) begin
            pop_c = 1'b1;
          end else begin
            state_d = OREG_EMPTY;
          end
        end
      end
      default: state_d = OREG_EMPTY;
    endcase

    if (pop_c) begin
      oreg_d   = head_c;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (in_valid && !ready_c && !rst && !flush) begin
      overflow_d = 1'b1;
      drop_inc_c = 1'b1;
    end
    if (accept_c && !in_bounds_c) begin
      drop_inc_c = 1'b1;
    end
    if (drop_inc_c && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Flush empties storage but keeps the error statistics for control.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = OREG_EMPTY;
      oreg_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= OREG_EMPTY;
      oreg_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      oreg_q     <= oreg_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign in_ready    = ready_c;
  assign event_out   = oreg_q;
  assign event_valid = (state_q == OREG_HOLD);
  assign fill_level  = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_event_input_fifo.sv
// Self-checking bench for event_input_fifo: directed scenarios plus random
// traffic, checked against a queue-based model of the FIFO's ordering rules.
module tb_event_input_fifo;
  import snn_interfaces_pkg::*;

  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_timestep = '0;
  logic [7:0]     in_x = '0;
  logic [7:0]     in_y = '0;
  logic [1:0]     in_spikes = '0;
  output_vector_t event_out;
  logic           event_valid;
  logic           event_ack = 1'b0;
  logic [4:0]     fill_level;
  logic           overflow;
  logic [15:0]    drop_count;

  int nCompared = 0;
  int nMismatched = 0;

  // Model: events waiting in the array, plus what the consumer currently sees.
  output_vector_t arrQ[$];
  bit             oValid = 1'b0;
  output_vector_t oVal = '0;
  bit             mOvf = 1'b0;
  int             mDrops = 0;

  event_input_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_timestep (in_timestep),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_spikes   (in_spikes),
    .event_out   (event_out),
    .event_valid (event_valid),
    .event_ack   (event_ack),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seqX(int i);
`ifdef EVENT_FIFO_BOUNDS_CHECK_EN
    return 8'(i % 8);
`else
    return 8'(i);
`endif
  endfunction

  function automatic bit modelReady();
    return (arrQ.size() < DEPTH) && !rst && !flush;
  endfunction

  // Offer one event (sequence number carried in the timestep field).
  task automatic offer(int seq);
    in_valid    = 1'b1;
    in_timestep = 8'(seq);
    in_x        = seqX(seq);
    in_y        = 8'($urandom_range(0, 7));
    in_spikes   = 2'($urandom_range(0, 3));
  endtask

  // Advance one clock edge and apply the FIFO rules to the model.
  task automatic tick();
    bit ready;
    bit inB;
    ready = modelReady();
    @(posedge clk);
    if (rst) begin
      arrQ.delete(); oValid = 1'b0; oVal = '0; mOvf = 1'b0; mDrops = 0;
    end else if (flush) begin
      arrQ.delete(); oValid = 1'b0; oVal = '0;
    end else begin
      if (in_valid && !ready) begin
        mOvf = 1'b1;
        if (mDrops < 65535) mDrops++;
      end
      if (!oValid) begin
        if (arrQ.size() > 0) begin oVal = arrQ.pop_front(); oValid = 1'b1; end
      end else if (event_ack) begin
        if (arrQ.size() > 0) oVal = arrQ.pop_front();
        else oValid = 1'b0;
      end
      if (in_valid && ready) begin
`ifdef EVENT_FIFO_BOUNDS_CHECK_EN
        inB = (in_x < 8) && (in_y < 8);
`else
        inB = 1'b1;
`endif
        if (inB) arrQ.push_back({in_timestep, in_x, in_y, in_spikes});
        else if (mDrops < 65535) mDrops++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; event_ack = 1'b0;
    tick();
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    nCompared++; if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %0b want 0", event_valid); end
    nCompared++; if (event_out !== '0) begin nMismatched++; $display("[TB] FAIL reset_out: got %h want 0", event_out); end
    nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_fill: got %0d want 0", fill_level); end
    nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ovf: got %0b want 0", overflow); end
    nCompared++; if (drop_count !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_drops: got %0d want 0", drop_count); end
    rst = 1'b0;
    #1;
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    output_vector_t expEv;
    expEv = {8'd0, 8'd5, 8'd3, 2'b11};
    in_valid = 1'b1; in_timestep = 8'd0; in_x = 8'd5; in_y = 8'd3; in_spikes = 2'b11;
    tick();
    in_valid = 1'b0;
    nCompared++; if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_latency1: got %0b want 0", event_valid); end
    tick();
    nCompared++; if (event_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_latency2: got %0b want 1", event_valid); end
    nCompared++; if (event_out !== expEv) begin nMismatched++; $display("[TB] FAIL single_out: got %h want %h", event_out, expEv); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++; if (event_valid !== 1'b1 || event_out !== expEv) begin nMismatched++; $display("[TB] FAIL single_hold: got %0b/%h want 1/%h", event_valid, event_out, expEv); end
    end
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
    nCompared++; if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_after_ack: got %0b want 0", event_valid); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 16; i++) begin
      offer(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    nCompared++; if (fill_level !== 5'd15) begin nMismatched++; $display("[TB] FAIL burst_fill15: got %0d want 15", fill_level); end
    nCompared++; if (event_valid !== 1'b1 || event_out.timestep !== 8'd0) begin nMismatched++; $display("[TB] FAIL burst_head: got %0b/%0d want 1/0", event_valid, event_out.timestep); end
    nCompared++; if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL burst_ready15: got %0b want 1", in_ready); end
    offer(16);
    tick();
    nCompared++; if (fill_level !== 5'd16) begin nMismatched++; $display("[TB] FAIL burst_fill16: got %0d want 16", fill_level); end
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL burst_full_ready: got %0b want 0", in_ready); end
    offer(17);
    tick();
    in_valid = 1'b0;
    nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL burst_ovf: got %0b want 1", overflow); end
    nCompared++; if (drop_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL burst_drops: got %0d want 1", drop_count); end
    nCompared++; if (fill_level !== 5'd16) begin nMismatched++; $display("[TB] FAIL burst_fill_after_drop: got %0d want 16", fill_level); end
  endtask

  task automatic test_drain();
    event_ack = 1'b1;
    for (int i = 0; i < 17; i++) begin
      nCompared++; if (event_valid !== 1'b1 || event_out.timestep !== 8'(i) || event_out !== oVal) begin nMismatched++; $display("[TB] FAIL drain_seq%0d: got %0b/%h want 1/%h", i, event_valid, event_out, oVal); end
      tick();
    end
    event_ack = 1'b0;
    nCompared++; if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_end_valid: got %0b want 0", event_valid); end
    nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL drain_end_fill: got %0d want 0", fill_level); end
  endtask

  task automatic test_concurrent();
    int steady;
    for (int i = 0; i < 4; i++) begin
      offer(i);
      tick();
    end
    steady = arrQ.size();
    event_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      offer(i + 4);
      nCompared++; if (event_valid !== 1'b1 || event_out.timestep !== 8'(i)) begin nMismatched++; $display("[TB] FAIL conc_order%0d: got %0b/%0d want 1/%0d", i, event_valid, event_out.timestep, i); end
      tick();
      nCompared++; if (fill_level !== 5'(steady)) begin nMismatched++; $display("[TB] FAIL conc_fill%0d: got %0d want %0d", i, fill_level, steady); end
    end
    in_valid = 1'b0;
    nCompared++; if (drop_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL conc_drops: got %0d want 1", drop_count); end
    for (int j = 40; j < 44; j++) begin
      nCompared++; if (event_valid !== 1'b1 || event_out.timestep !== 8'(j)) begin nMismatched++; $display("[TB] FAIL conc_tail%0d: got %0b/%0d want 1/%0d", j, event_valid, event_out.timestep, j); end
      tick();
    end
    event_ack = 1'b0;
    nCompared++; if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL conc_empty: got %0b want 0", event_valid); end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) begin
      offer(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    offer(99);
    flush = 1'b1;
    #1;
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_ready: got %0b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nCompared++; if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_valid: got %0b want 0", event_valid); end
    nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL flush_fill: got %0d want 0", fill_level); end
    nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_ovf_kept: got %0b want 1", overflow); end
    nCompared++; if (drop_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL flush_drops_kept: got %0d want 1", drop_count); end
    for (int i = 0; i < 2; i++) begin
      offer(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    nCompared++; if (event_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL prereset_hold: got %0b want 1", event_valid); end
    rst = 1'b1;
    tick();
    nCompared++; if (event_valid !== 1'b0 || event_out !== '0 || fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL midreset_state: got %0b/%h/%0d want 0/0/0", event_valid, event_out, fill_level); end
    nCompared++; if (overflow !== 1'b0 || drop_count !== 16'd0 || in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_stats: got %0b/%0d/%0b want 0/0/0", overflow, drop_count, in_ready); end
    rst = 1'b0;
  endtask

`ifdef EVENT_FIFO_BOUNDS_CHECK_EN
  task automatic test_bounds();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_timestep = 8'd1; in_x = 8'd8; in_y = 8'd0; in_spikes = 2'b01;
    tick();
    in_timestep = 8'd2; in_x = 8'd7; in_y = 8'd7; in_spikes = 2'b10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    nCompared++; if (event_valid !== 1'b1 || event_out.x !== 8'd7 || event_out.y !== 8'd7) begin nMismatched++; $display("[TB] FAIL bounds_out: got %0b/%0d,%0d want 1/7,7", event_valid, event_out.x, event_out.y); end
    nCompared++; if (drop_count !== 16'd1 || overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL bounds_stats: got %0d/%0b want 1/0", drop_count, overflow); end
    event_ack = 1'b1;
    tick();
    event_ack = 1'b0;
    nCompared++; if (event_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bounds_only_one: got %0b want 0", event_valid); end
  endtask
`endif

  task automatic test_random();
    bit expReady;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 500; c++) begin
      in_valid    = ($urandom_range(0, 99) < 70);
      in_timestep = 8'($urandom);
`ifdef EVENT_FIFO_BOUNDS_CHECK_EN
      in_x        = 8'($urandom_range(0, 9));
      in_y        = 8'($urandom_range(0, 9));
`else
      in_x        = 8'($urandom);
      in_y        = 8'($urandom);
`endif
      in_spikes   = 2'($urandom_range(0, 3));
      event_ack   = ($urandom_range(0, 99) < 45);
      flush       = ($urandom_range(0, 99) < 3);
      #1;
      expReady = modelReady();
      nCompared++; if (in_ready !== expReady) begin nMismatched++; $display("[TB] FAIL rnd_ready@%0d: got %0b want %0b", c, in_ready, expReady); end
      tick();
      nCompared++; if (event_valid !== oValid) begin nMismatched++; $display("[TB] FAIL rnd_valid@%0d: got %0b want %0b", c, event_valid, oValid); end
      if (oValid) begin
        nCompared++; if (event_out !== oVal) begin nMismatched++; $display("[TB] FAIL rnd_out@%0d: got %h want %h", c, event_out, oVal); end
      end
      nCompared++; if (fill_level !== 5'(arrQ.size())) begin nMismatched++; $display("[TB] FAIL rnd_fill@%0d: got %0d want %0d", c, fill_level, arrQ.size()); end
      nCompared++; if (overflow !== mOvf || drop_count !== 16'(mDrops)) begin nMismatched++; $display("[TB] FAIL rnd_stats@%0d: got %0b/%0d want %0b/%0d", c, overflow, drop_count, mOvf, mDrops); end
    end
    in_valid = 1'b0; event_ack = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_drain();
    test_concurrent();
    test_flush_reset();
`ifdef EVENT_FIFO_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
